layer_1_output_streamer: RTL and testbench

Consumer end of the layer-1 compute interface. On each completion pulse from layer_1_complete, snapshots all NEURON_COUNT leaky-ReLU results in one cycle. It then streams them, one per transfer and in index order, over a valid/ready handshake toward the layer-2 datapath. This frees layer_1_complete to start the next image while results drain.

---
 rtl/layer_1_pkg.sv | 21 ++
 rtl/layer_1_snapshot_bank.sv | 40 ++++
 rtl/layer_1_output_streamer.sv | 110 +++++++++++
 tb/tb_layer_1_output_streamer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_1_pkg.sv
// Shared parameters and bus conventions for the layer-1 output path.
// Neuron i occupies bits [i*WORD_WIDTH +: WORD_WIDTH] of the flattened result bus.
package layer_1_pkg;

    localparam int NEURON_COUNT    = 20;
    localparam int OUTPUT_BUT_SIZE = 16;
    localparam int WORD_WIDTH      = 2 * OUTPUT_BUT_SIZE;
    localparam int INDEX_WIDTH     = 5;
    localparam int BUS_WIDTH       = NEURON_COUNT * WORD_WIDTH;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    function automatic logic [WORD_WIDTH-1:0] bus_word(
        input logic [BUS_WIDTH-1:0] bus,
        input int                   idx
    );
        return bus[idx*WORD_WIDTH +: WORD_WIDTH];
    endfunction

endpackage

// File: rtl/layer_1_snapshot_bank.sv
// DEPTH x WIDTH register bank: all entries load in parallel on one strobe,
// one entry is read back through an indexed mux.
module layer_1_snapshot_bank
    import layer_1_pkg::*;
#(
    parameter int DEPTH = NEURON_COUNT,
    parameter int WIDTH = WORD_WIDTH,
    parameter int IDX_W = INDEX_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data [DEPTH],
    input  logic [IDX_W-1:0] rd_index,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] bank [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= load_data[i];
            end
        end
    end

    // Out-of-range indices read as zero rather than aliasing another entry.
    always_comb begin
        rd_data = '0;
        if (int'(rd_index) < DEPTH) begin
            rd_data = bank[rd_index];
        end
    end

endmodule

// File: rtl/layer_1_output_streamer.sv
// Captures a full frame of layer-1 results on a completion edge and streams
// them in index order over a valid/ready handshake.
module layer_1_output_streamer
    import layer_1_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   done_complete,
    input  logic [BUS_WIDTH-1:0]   layer_1_outputs,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [WORD_WIDTH-1:0]  out_data,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic                   out_last,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   overrun
);

    // Handshake: a word moves on every rising edge where out_valid and
    // out_ready are both high; out_valid comes only from registered state and
    // the presented word stays frozen until it is taken.

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NEURON_COUNT - 1);

    logic [0:0]             state;
    logic [INDEX_WIDTH-1:0] index;
    logic                   done_prev;
    logic                   rise;
    logic                   xfer;
    logic                   at_last;
    logic                   last_xfer;
    logic                   load;
    logic [WORD_WIDTH-1:0]  frame_words [NEURON_COUNT];

    always_comb begin
        for (int i = 0; i < NEURON_COUNT; i++) begin
            frame_words[i] = bus_word(layer_1_outputs, i);
        end
    end

    assign rise      = done_complete & ~done_prev;
    assign out_valid = (state == ST_STREAM);
    assign busy      = out_valid;
    assign at_last   = (index == LAST_INDEX);
    assign xfer      = out_valid & out_ready;
    assign last_xfer = xfer & at_last;
    // A new frame is accepted when idle or exactly as the old one drains.
    assign load      = rise & (~out_valid | last_xfer);
    assign out_last  = out_valid & at_last;
    assign out_index = index;

    // Resets high so a level already asserted at reset release is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_prev <= 1'b1;
        end else begin
            done_prev <= done_complete;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            index      <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= last_xfer;
            if (rise & out_valid & ~last_xfer) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state <= ST_STREAM;
                        index <= '0;
                    end
                end
                ST_STREAM: begin
                    if (xfer) begin
                        if (at_last) begin
                            index <= '0;
                            if (!rise) begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            index <= index + INDEX_WIDTH'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    layer_1_snapshot_bank #(
        .DEPTH (NEURON_COUNT),
        .WIDTH (WORD_WIDTH),
        .IDX_W (INDEX_WIDTH)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (frame_words),
        .rd_index  (index),
        .rd_data   (out_data)
    );

endmodule

// File: tb/tb_layer_1_output_streamer.sv
// Randomised bench for layer_1_output_streamer against a frame-queue model.
module tb_layer_1_output_streamer;
    import layer_1_pkg::*;

    logic                   clk;
    logic                   reset;
    logic                   done_complete;
    logic [BUS_WIDTH-1:0]   layer_1_outputs;
    logic                   out_ready;
    logic                   out_valid;
    logic [WORD_WIDTH-1:0]  out_data;
    logic [INDEX_WIDTH-1:0] out_index;
    logic                   out_last;
    logic                   frame_done;
    logic                   busy;
    logic                   overrun;

    layer_1_output_streamer dut (
        .clk             (clk),
        .reset           (reset),
        .done_complete   (done_complete),
        .layer_1_outputs (layer_1_outputs),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_index       (out_index),
        .out_last        (out_last),
        .frame_done      (frame_done),
        .busy            (busy),
        .overrun         (overrun)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int fd_count = 0;

    logic [WORD_WIDTH-1:0] words [NEURON_COUNT];
    logic [WORD_WIDTH-1:0] exp_q [$];
    bit m_prev;
    bit m_fd;
    bit m_ov;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_prev = 1'b1;
        m_fd   = 1'b0;
        m_ov   = 1'b0;
    endtask

    // Advances the model across one clock edge using the inputs now driven.
    task automatic model_step();
        bit rise;
        bit xfer;
        bit last;
        int sz;
        rise   = done_complete && !m_prev;
        m_prev = done_complete;
        sz     = exp_q.size();
        xfer   = (sz > 0) && out_ready;
        last   = xfer && (sz == 1);
        m_fd   = last;
        if (xfer) void'(exp_q.pop_front());
        if (rise) begin
            if (sz == 0 || last) begin
                for (int i = 0; i < NEURON_COUNT; i++) exp_q.push_back(words[i]);
            end else begin
                m_ov = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = exp_q.size();
        check("valid", 32'(out_valid), 32'(sz > 0));
        check("busy", 32'(busy), 32'(sz > 0));
        check("index", 32'(out_index), (sz == 0) ? 32'd0 : 32'(NEURON_COUNT - sz));
        check("last", 32'(out_last), 32'(sz == 1));
        if (sz > 0) check("data", out_data, exp_q[0]);
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("overrun", 32'(overrun), 32'(m_ov));
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_bus();
        for (int i = 0; i < NEURON_COUNT; i++) begin
            layer_1_outputs[i*WORD_WIDTH +: WORD_WIDTH] = words[i];
        end
    endtask

    task automatic load_inc(input logic [WORD_WIDTH-1:0] base);
        for (int i = 0; i < NEURON_COUNT; i++) words[i] = base + WORD_WIDTH'(i);
        set_bus();
    endtask

    task automatic load_random();
        for (int i = 0; i < NEURON_COUNT; i++) words[i] = $urandom;
        set_bus();
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        if (frame_done) fd_count++;
        check_outputs();
    endtask

    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    // ---------------- stimulus ----------------
    initial begin
        reset           = 1'b1;
        done_complete   = 1'b0;
        out_ready       = 1'b0;
        layer_1_outputs = '0;
        for (int i = 0; i < NEURON_COUNT; i++) words[i] = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", out_data, 32'd0);
        check_outputs();
        reset = 1'b0;

        // Single frame, ready always high.
        load_inc(32'h0000_0100);
        out_ready = 1'b1;
        repeat (5) tick();
        done_complete = 1'b1;
        tick();
        done_complete = 1'b0;
        check("t1_first_data", out_data, 32'h0000_0100);
        fd_count = 0;
        repeat (22) tick();
        check("t1_frames", 32'(fd_count), 32'd1);

        // Backpressure with ready pattern 1,0,0,1.
        load_random();
        done_complete = 1'b1;
        tick();
        done_complete = 1'b0;
        fd_count = 0;
        for (int c = 0; c < 60; c++) begin
            out_ready = pat[c % 4];
            tick();
        end
        check("t2_frames", 32'(fd_count), 32'd1);

        // Held-level done triggers one frame only.
        load_random();
        out_ready     = 1'b1;
        done_complete = 1'b1;
        fd_count = 0;
        repeat (50) tick();
        done_complete = 1'b0;
        repeat (3) tick();
        check("t3_frames", 32'(fd_count), 32'd1);
        check("t3_overrun", 32'(overrun), 32'd0);

        // Back-to-back: new rise on the final transfer.
        load_random();
        done_complete = 1'b1;
        tick();
        done_complete = 1'b0;
        repeat (19) tick();
        load_random();
        done_complete = 1'b1;
        tick();
        done_complete = 1'b0;
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_index", 32'(out_index), 32'd0);
        check("b2b_data", out_data, words[0]);
        check("b2b_frame_done", 32'(frame_done), 32'd1);
        repeat (22) tick();
        check("b2b_overrun", 32'(overrun), 32'd0);

        // Overrun: second rise mid-frame with a changed bus.
        load_random();
        done_complete = 1'b1;
        tick();
        done_complete = 1'b0;
        repeat (5) tick();
        for (int i = 0; i < NEURON_COUNT; i++) words[i] = 32'hFFFF_FFFF;
        set_bus();
        done_complete = 1'b1;
        tick();
        done_complete = 1'b0;
        repeat (20) tick();
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Reset mid-frame with done held high.
        load_random();
        tick();
        done_complete = 1'b1;
        tick();
        repeat (7) tick();
        reset = 1'b1;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_outputs();
        repeat (5) tick();
        check("rst_no_capture", 32'(out_valid), 32'd0);
        done_complete = 1'b0;
        tick();
        load_random();
        done_complete = 1'b1;
        tick();
        check("rst_restart_index", 32'(out_index), 32'd0);
        done_complete = 1'b0;
        repeat (22) tick();

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 19) == 0) done_complete = ~done_complete;
            out_ready = ($urandom_range(0, 3) != 0);
            load_random();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
